opt_gen: RTL and testbench



---
 rtl/replica_pkg.sv | 45 ++++
 rtl/opt_gen_if.sv | 27 ++
 rtl/xorshift32.sv | 31 +++
 rtl/opt_gen.sv | 165 ++++++++++++++++
 tb/tb_opt_gen.sv | 395 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/replica_pkg.sv
// Shared types and constants for the replica move pipeline.
package replica_pkg;

  localparam int unsigned city_num = 32;
  localparam int unsigned city_log = 5;

  localparam int unsigned XS_SHIFT_A = 13;
  localparam int unsigned XS_SHIFT_B = 17;
  localparam int unsigned XS_SHIFT_C = 5;

  localparam logic [31:0] OPT_SEED_DEFAULT = 32'h2545F491;

  typedef enum logic [1:0] {
    THR = 2'd0,
    TWO = 2'd1,
    OR0 = 2'd2,
    OR1 = 2'd3
  } opt_command_t;

  typedef logic [city_log-1:0] city_t;

  typedef struct packed {
    opt_command_t com;
    city_t        K;
    city_t        L;
    logic [22:0]  r_metropolis;
    logic [22:0]  r_exchange;
  } opt_t;

  // One xorshift32 step (13, 17, 5).
  function automatic logic [31:0] xorshift32_step(input logic [31:0] x);
    logic [31:0] v;
    v = x;
    v = v ^ (v << XS_SHIFT_A);
    v = v ^ (v >> XS_SHIFT_B);
    v = v ^ (v << XS_SHIFT_C);
    return v;
  endfunction

  // xorshift locks up at zero, so zero seeds are mapped to 1.
  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == '0) ? 32'h1 : s;
  endfunction

endpackage

// File: rtl/opt_gen_if.sv
// Proposal bus between opt_gen (slave side) and its consumer/seed source (master side).
interface opt_gen_if;
  import replica_pkg::*;

  logic        seed_we;
  logic [31:0] seed_data;
  logic        opt_run;
  opt_t        out_opt;
  logic        busy;

  modport master (
    output seed_we,
    output seed_data,
    output opt_run,
    input  out_opt,
    input  busy
  );

  modport slave (
    input  seed_we,
    input  seed_data,
    input  opt_run,
    output out_opt,
    output busy
  );

endinterface

// File: rtl/xorshift32.sv
// xorshift32 PRNG: state register with step enable and a load port.
// rnd_o is the value the state takes on the next enabled step.
module xorshift32
  import replica_pkg::*;
#(
  parameter logic [31:0] RESET_STATE = 32'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        load_i,
  input  logic [31:0] load_data_i,
  output logic [31:0] rnd_o
);

  logic [31:0] state_q;

  assign rnd_o = xorshift32_step(state_q);

  // State update: load has priority over stepping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_STATE;
    end else if (load_i) begin
      state_q <= seed_fix(load_data_i);
    end else if (en_i) begin
      state_q <= rnd_o;
    end
  end

endmodule

// File: rtl/opt_gen.sv
// opt_gen: per-replica move proposer feeding metropolis in_opt.
// Optional build macro: OPT_STALL_CNT_EN adds the saturating stall_cnt port.
module opt_gen
  import replica_pkg::*;
#(
  parameter int unsigned id     = 0,
  parameter logic [31:0] seed   = OPT_SEED_DEFAULT,
  parameter int unsigned city_n = city_num
) (
  input  logic        clk,
  input  logic        reset,
  opt_gen_if.slave    bus
`ifdef OPT_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam logic [31:0] RESET_STATE = seed_fix(seed ^ 32'(id + 1));

  localparam logic [2:0] S_DRAW_K = 3'd0;
  localparam logic [2:0] S_DRAW_L = 3'd1;
  localparam logic [2:0] S_DRAW_R = 3'd2;
  localparam logic [2:0] S_DRAW_X = 3'd3;
  localparam logic [2:0] S_READY  = 3'd4;

  localparam logic signed [city_log:0] TWO_MIN_DIST = 2;

  logic [2:0]  state_q, state_d;
  opt_t        pend_q, pend_d;
  opt_t        out_q, out_d;
  logic        prng_en;
  logic [31:0] rnd;

  city_t                      c;
  logic                       c_valid;
  logic signed [city_log:0]   diff;
  logic signed [city_log:0]   absdiff;
  logic                       two_ok;
  logic                       or_ok;
  logic                       unused_rnd_bits;

  xorshift32 #(
    .RESET_STATE (RESET_STATE)
  ) u_prng (
    .clk         (clk),
    .rst         (reset),
    .en_i        (prng_en),
    .load_i      (bus.seed_we),
    .load_data_i (bus.seed_data),
    .rnd_o       (rnd)
  );

  assign c               = rnd[city_log-1:0];
  assign c_valid         = (32'(c) < city_n);
  assign diff            = $signed({1'b0, c}) - $signed({1'b0, pend_q.K});
  assign absdiff         = diff[city_log] ? -diff : diff;
  assign two_ok          = (c != '0) && (absdiff >= TWO_MIN_DIST);
  assign or_ok           = (c != pend_q.K) && (c != city_t'(pend_q.K - 1'b1));
  assign unused_rnd_bits = ^rnd[30:23];

  // Next-state: draw sequencing, candidate filtering, slot handling.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    out_d   = out_q;
    prng_en = 1'b0;

    case (state_q)
      S_DRAW_K: begin
        prng_en = 1'b1;
        if ((c != '0) && c_valid) begin
          pend_d.K   = c;
          pend_d.com = rnd[31] ? OR0 : TWO;
          state_d    = S_DRAW_L;
        end
      end
      S_DRAW_L: begin
        prng_en = 1'b1;
        if (c_valid) begin
          if (pend_q.com == TWO) begin
            if (two_ok) begin
              pend_d.K = (c < pend_q.K) ? c : pend_q.K;
              pend_d.L = (c < pend_q.K) ? pend_q.K : c;
              state_d  = S_DRAW_R;
            end
          end else if (or_ok) begin
            pend_d.L = c;
            state_d  = S_DRAW_R;
          end
        end
      end
      S_DRAW_R: begin
        prng_en             = 1'b1;
        pend_d.r_metropolis = rnd[22:0];
        state_d             = S_DRAW_X;
      end
      S_DRAW_X: begin
        prng_en           = 1'b1;
        pend_d.r_exchange = rnd[22:0];
        state_d           = S_READY;
      end
      S_READY: begin
        if (bus.opt_run) begin
          out_d   = pend_q;
          state_d = S_DRAW_K;
        end
      end
      default: begin
        state_d = S_DRAW_K;
      end
    endcase

    if (bus.opt_run && (state_q != S_READY)) begin
      out_d.com = THR;
    end

    // Reseeding restarts the draw; a slot in the same cycle must not
    // release the discarded pending proposal.
    if (bus.seed_we) begin
      prng_en = 1'b0;
      state_d = S_DRAW_K;
      pend_d  = '0;
      if (bus.opt_run) begin
        out_d     = out_q;
        out_d.com = THR;
      end
    end
  end

  // State, pending proposal and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_DRAW_K;
      pend_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
    end
  end

  assign bus.out_opt = out_q;
  assign bus.busy    = (state_q != S_READY);

`ifdef OPT_STALL_CNT_EN
  logic        bubble;
  logic [15:0] stall_q;

  assign bubble = bus.opt_run && (bus.seed_we || (state_q != S_READY));

  // Saturating count of emitted THR bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (bubble && (stall_q != '1)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_opt_gen.sv
// Directed self-checking bench for opt_gen with a reference xorshift/draw model.
module tb_opt_gen;
  import replica_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  opt_gen_if bus_a ();
  opt_gen_if bus_c ();

`ifdef OPT_STALL_CNT_EN
  logic [15:0] stall_a;
  logic [15:0] stall_c;
`endif

  opt_gen #(
    .id     (0),
    .seed   (32'h0),
    .city_n (32)
  ) dut_a (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_a)
`ifdef OPT_STALL_CNT_EN
    ,
    .stall_cnt (stall_a)
`endif
  );

  opt_gen #(
    .id     (0),
    .seed   (32'h0),
    .city_n (3)
  ) dut_c (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_c)
`ifdef OPT_STALL_CNT_EN
    ,
    .stall_cnt (stall_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  opt_t        p_seed1;
  int          tot_seed1;
  logic [31:0] mst;

  function automatic logic [31:0] xs(input logic [31:0] v);
    logic [31:0] x;
    x = v;
    x = x ^ (x << 13);
    x = x ^ (x >> 17);
    x = x ^ (x << 5);
    return x;
  endfunction

  // Reference: draws one proposal from PRNG state st; kc/lc are cycles
  // spent in DRAW_K/DRAW_L, stuck flags a DRAW_L that never accepts.
  task automatic model_prop(input int cn, inout logic [31:0] st, output opt_t p,
                            output int kc, output int lc, output bit stuck);
    int c, k, d;
    bit two, ok;
    kc = 0; lc = 0; stuck = 0; p = '0;
    do begin
      st = xs(st); kc++; c = int'(st[4:0]);
    end while (!(c >= 1 && c <= cn - 1) && kc < 5000);
    k = c;
    two = (st[31] == 1'b0);
    ok = 0;
    while (!ok && !stuck) begin
      st = xs(st); lc++; c = int'(st[4:0]);
      d = (c > k) ? c - k : k - c;
      if (two) ok = (c >= 1) && (c <= cn - 1) && (d >= 2);
      else     ok = (c <= cn - 1) && (c != k) && (c != k - 1);
      if (!ok && lc >= 400) stuck = 1;
    end
    if (!stuck) begin
      if (two) begin
        p.com = TWO;
        p.K = 5'((c < k) ? c : k);
        p.L = 5'((c < k) ? k : c);
      end else begin
        p.com = OR0;
        p.K = 5'(k);
        p.L = 5'(c);
      end
      st = xs(st); p.r_metropolis = st[22:0];
      st = xs(st); p.r_exchange   = st[22:0];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for busy to fall on the selected instance.
  task automatic wait_ready(input bit sel_c, input int limit, output int n);
    n = 0;
    while (((sel_c ? bus_c.busy : bus_a.busy) === 1'b1) && n < limit) begin
      tick();
      n++;
    end
    if (n >= limit) begin
      checks++;
      errors++;
      $display("FAIL wait_ready timeout: busy still %b after %0d cycles, required 0",
               sel_c ? bus_c.busy : bus_a.busy, n);
    end
  endtask

  task automatic test_reset();
    opt_t p;
    int kc, lc, n;
    bit stuck;
    rst = 1'b1;
    #2;
    checks++;
    if (bus_a.out_opt !== opt_t'('0)) begin
      errors++; $display("FAIL reset_out: got %h required 0", bus_a.out_opt);
    end
    checks++;
    if (bus_a.busy !== 1'b1) begin
      errors++; $display("FAIL reset_busy: got %b required 1", bus_a.busy);
    end
`ifdef OPT_STALL_CNT_EN
    checks++;
    if (stall_a !== 16'd0) begin
      errors++; $display("FAIL reset_stall: got %0d required 0", stall_a);
    end
`endif
    tick(); tick();
    rst = 1'b0;
    mst = 32'h1;
    model_prop(32, mst, p, kc, lc, stuck);
    p_seed1 = p;
    tot_seed1 = kc + lc + 2;
    wait_ready(1'b0, 200, n);
    checks++;
    if (n != tot_seed1) begin
      errors++; $display("FAIL first_latency: got %0d required %0d", n, tot_seed1);
    end
    repeat (3) tick();
    checks++;
    if (bus_a.out_opt.com !== THR) begin
      errors++; $display("FAIL hold_thr_before_run: got %0d required THR", bus_a.out_opt.com);
    end
    bus_a.opt_run = 1'b1;
    tick();
    bus_a.opt_run = 1'b0;
    checks++;
    if (bus_a.out_opt !== p_seed1) begin
      errors++; $display("FAIL first_prop: got %h required %h", bus_a.out_opt, p_seed1);
    end
    checks++;
    if (bus_a.out_opt.K !== 5'd1 || bus_a.out_opt.com !== TWO) begin
      errors++; $display("FAIL first_k_com: got K=%0d com=%0d required K=1 com=TWO",
                         bus_a.out_opt.K, bus_a.out_opt.com);
    end
    checks++;
    if (bus_a.busy !== 1'b1) begin
      errors++; $display("FAIL busy_after_consume: got %b required 1", bus_a.busy);
    end
  endtask

  task automatic test_async_reset();
    opt_t p;
    int kc, lc, n;
    bit stuck;
    model_prop(32, mst, p, kc, lc, stuck);
    repeat (kc + lc) tick();
    checks++;
    if (bus_a.busy !== 1'b1) begin
      errors++; $display("FAIL draw_r_busy: got %b required 1", bus_a.busy);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus_a.out_opt !== opt_t'('0)) begin
      errors++; $display("FAIL async_reset_out: got %h required 0", bus_a.out_opt);
    end
    checks++;
    if (bus_a.busy !== 1'b1) begin
      errors++; $display("FAIL async_reset_busy: got %b required 1", bus_a.busy);
    end
    tick();
    rst = 1'b0;
    mst = 32'h1;
    model_prop(32, mst, p, kc, lc, stuck);
    wait_ready(1'b0, 200, n);
    checks++;
    if (n != tot_seed1) begin
      errors++; $display("FAIL async_restart_latency: got %0d required %0d", n, tot_seed1);
    end
    bus_a.opt_run = 1'b1;
    tick();
    bus_a.opt_run = 1'b0;
    checks++;
    if (bus_a.out_opt !== p_seed1) begin
      errors++; $display("FAIL async_restart_prop: got %h required %h", bus_a.out_opt, p_seed1);
    end
  endtask

  task automatic test_seed_mid();
    opt_t p;
    city_t old_k;
    int kc, lc, n;
    bit stuck;
    model_prop(32, mst, p, kc, lc, stuck);
    repeat (kc) tick();
    checks++;
    if (bus_a.busy !== 1'b1) begin
      errors++; $display("FAIL seed_mid_busy: got %b required 1", bus_a.busy);
    end
    old_k = bus_a.out_opt.K;
    bus_a.seed_we   = 1'b1;
    bus_a.seed_data = 32'h1;
    bus_a.opt_run   = 1'b1;
    tick();
    bus_a.seed_we = 1'b0;
    bus_a.opt_run = 1'b0;
    checks++;
    if (bus_a.out_opt.com !== THR || bus_a.out_opt.K !== old_k) begin
      errors++; $display("FAIL seed_bubble: got com=%0d K=%0d required com=THR K=%0d",
                         bus_a.out_opt.com, bus_a.out_opt.K, old_k);
    end
    mst = 32'h1;
    model_prop(32, mst, p, kc, lc, stuck);
    wait_ready(1'b0, 200, n);
    checks++;
    if (n != tot_seed1) begin
      errors++; $display("FAIL reseed_latency: got %0d required %0d", n, tot_seed1);
    end
    bus_a.opt_run = 1'b1;
    tick();
    bus_a.opt_run = 1'b0;
    checks++;
    if (bus_a.out_opt !== p_seed1) begin
      errors++; $display("FAIL reseed_prop: got %h required %h", bus_a.out_opt, p_seed1);
    end
  endtask

  task automatic test_back_to_back();
    opt_t p;
    city_t prev_k;
    int kc, lc, tot, sumb;
    bit stuck;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_a.opt_run = 1'b1;
    mst = 32'h1;
    sumb = 0;
    prev_k = '0;
    for (int j = 0; j < 3; j++) begin
      model_prop(32, mst, p, kc, lc, stuck);
      tot = kc + lc + 2;
      for (int i = 0; i < tot; i++) begin
        tick();
        checks++;
        if (bus_a.out_opt.com !== THR || bus_a.out_opt.K !== prev_k) begin
          errors++; $display("FAIL bubble[%0d.%0d]: got com=%0d K=%0d required com=THR K=%0d",
                             j, i, bus_a.out_opt.com, bus_a.out_opt.K, prev_k);
        end
      end
      sumb += tot;
      tick();
      checks++;
      if (bus_a.out_opt !== p) begin
        errors++; $display("FAIL b2b_prop[%0d]: got %h required %h", j, bus_a.out_opt, p);
      end
      prev_k = p.K;
    end
    bus_a.opt_run = 1'b0;
`ifdef OPT_STALL_CNT_EN
    checks++;
    if (stall_a !== 16'(sumb)) begin
      errors++; $display("FAIL stall_count: got %0d required %0d", stall_a, sumb);
    end
`endif
  endtask

  task automatic test_random();
    opt_t p, o;
    int kc, lc;
    bit stuck, ok;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mst = 32'h1;
    for (int n = 0; n < 300; n++) begin
      model_prop(32, mst, p, kc, lc, stuck);
      repeat (63) tick();
      checks++;
      if (bus_a.busy !== 1'b0) begin
        errors++; $display("FAIL rand_ready[%0d]: busy=%b required 0", n, bus_a.busy);
      end
      bus_a.opt_run = 1'b1;
      tick();
      bus_a.opt_run = 1'b0;
      o = bus_a.out_opt;
      checks++;
      if (o !== p) begin
        errors++; $display("FAIL rand_prop[%0d]: got %h required %h", n, o, p);
      end
      if (o.com == TWO)
        ok = (o.K >= 5'd1) && (o.K < o.L) && (o.L - o.K >= 5'd2);
      else if (o.com == OR0)
        ok = (o.K >= 5'd1) && (o.L != o.K) && (o.L != o.K - 5'd1);
      else
        ok = 1'b0;
      checks++;
      if (!ok) begin
        errors++; $display("FAIL rand_legal[%0d]: got com=%0d K=%0d L=%0d required legal TWO/OR0",
                           n, o.com, o.K, o.L);
      end
    end
  endtask

  task automatic test_city3();
    opt_t p;
    int kc, lc, n;
    bit stuck, done, ok;
    for (int s = 1; s <= 12; s++) begin
      bus_c.seed_we   = 1'b1;
      bus_c.seed_data = 32'(s);
      tick();
      bus_c.seed_we = 1'b0;
      mst = 32'(s);
      done = 0;
      for (int j = 0; j < 3 && !done; j++) begin
        model_prop(3, mst, p, kc, lc, stuck);
        if (stuck) begin
          repeat (kc + 150) tick();
          checks++;
          if (bus_c.busy !== 1'b1) begin
            errors++; $display("FAIL c3_stuck_busy[s%0d]: got %b required 1", s, bus_c.busy);
          end
          bus_c.opt_run = 1'b1;
          tick();
          bus_c.opt_run = 1'b0;
          checks++;
          if (bus_c.out_opt.com !== THR) begin
            errors++; $display("FAIL c3_bubble[s%0d]: got %0d required THR", s, bus_c.out_opt.com);
          end
          done = 1;
        end else begin
          wait_ready(1'b1, 5000, n);
          checks++;
          if (n != kc + lc + 2) begin
            errors++; $display("FAIL c3_latency[s%0d]: got %0d required %0d", s, n, kc + lc + 2);
          end
          bus_c.opt_run = 1'b1;
          tick();
          bus_c.opt_run = 1'b0;
          checks++;
          if (bus_c.out_opt !== p) begin
            errors++; $display("FAIL c3_prop[s%0d]: got %h required %h", s, bus_c.out_opt, p);
          end
          ok = (bus_c.out_opt.com === OR0) &&
               ((bus_c.out_opt.K === 5'd1 && bus_c.out_opt.L === 5'd2) ||
                (bus_c.out_opt.K === 5'd2 && bus_c.out_opt.L === 5'd0));
          checks++;
          if (!ok) begin
            errors++; $display("FAIL c3_legal[s%0d]: got com=%0d K=%0d L=%0d required OR0 (1,2)/(2,0)",
                               s, bus_c.out_opt.com, bus_c.out_opt.K, bus_c.out_opt.L);
          end
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus_a.seed_we = 1'b0; bus_a.seed_data = '0; bus_a.opt_run = 1'b0;
    bus_c.seed_we = 1'b0; bus_c.seed_data = '0; bus_c.opt_run = 1'b0;
    test_reset();
    test_async_reset();
    test_seed_mid();
    test_back_to_back();
    test_random();
    test_city3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
